// File: rtl/comb_vector_checker_pkg.sv
// comb_vector_checker_pkg: FSM state encoding and MISR polynomial shared by the checker
package comb_vector_checker_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;
    localparam logic [15:0] MISR_POLY = 16'h6801;
endpackage

// File: rtl/comb_vector_checker_misr16.sv
// misr16: 16-bit Galois MISR (x^16+x^14+x^13+x^11+1) compacting one bit per enabled cycle
module misr16
    import comb_vector_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            sig <= '0;
        else if (en)
            sig <= {sig[14:0], 1'b0} ^ ({16{sig[15] ^ din}} & MISR_POLY);
    end
endmodule

// File: rtl/comb_vector_checker.sv
// comb_vector_checker: exhaustive on-chip sweep of an N_IN-input combinational block against a truth table
// Optional MISR signature of the sampled outputs when CVC_SIGNATURE_EN is defined.
module comb_vector_checker
    import comb_vector_checker_pkg::*;
#(
    parameter int          N_IN     = 6,
    parameter int          SETTLE   = 1,
    parameter logic [63:0] EXPECTED = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
`ifdef CVC_SIGNATURE_EN
    ,
    output logic [15:0]     signature
`endif
);
    state_t      state, state_n;
    logic [31:0] cnt;
    logic        clr, smp, last, miss;

    assign last = vec_out == '1;
    assign miss = y_in != EXPECTED[vec_out];
    assign busy = state == DRIVE || state == SAMPLE;
    assign done = state == DONE;
    assign pass = done && err_count == '0;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        smp     = 1'b0;
        case (state)
            IDLE, DONE: begin
                clr     = start;
                state_n = start ? DRIVE : state;
            end
            DRIVE:   state_n = (cnt == 32'(SETTLE - 1)) ? SAMPLE : DRIVE;
            default: begin
                smp     = 1'b1;
                state_n = last ? DONE : DRIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vec_out         <= '0;
            cnt             <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (state == DRIVE) begin
            cnt <= (state_n == SAMPLE) ? '0 : cnt + 32'd1;
        end else if (smp) begin
            if (miss) begin
                err_count <= err_count + (N_IN+1)'(1);
                if (!first_err_valid) begin
                    first_err_vec   <= vec_out;
                    first_err_valid <= 1'b1;
                end
            end
            if (!last)
                vec_out <= vec_out + N_IN'(1);
        end
    end

`ifdef CVC_SIGNATURE_EN
    misr16 u_misr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (smp),
        .din (y_in),
        .sig (signature)
    );
`endif
endmodule

// File: tb/tb_comb_vector_checker.sv
// tb_comb_vector_checker: directed checks of four checker instances (loopback, stuck-0, AND pattern, SETTLE=3)
module tb_comb_vector_checker;
    localparam logic [63:0] E0 = 64'hF0F0_F0F0_0000_FFFF;
    localparam logic [63:0] E1 = 64'h8000_0000_0000_0101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start = '0;
    logic [3:0] y, busy, done, pass, fv;
    logic [5:0] vec [4];
    logic [5:0] fev [4];
    logic [6:0] errc [4];
    logic       flip_en = 1'b0;
    logic [5:0] flip_v = '0;
    logic [63:0] e0 = E0;
`ifdef CVC_SIGNATURE_EN
    logic [15:0] sig [4];
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign y[0] = e0[vec[0]] ^ (flip_en && vec[0] == flip_v);
    assign y[1] = 1'b0;
    assign y[2] = vec[2][5] & vec[2][4] & vec[2][0];
    assign y[3] = e0[vec[3]];

    comb_vector_checker #(.N_IN(6), .SETTLE(1), .EXPECTED(E0)) d0 (
        .clk(clk), .rst(rst), .start(start[0]), .vec_out(vec[0]), .y_in(y[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .first_err_vec(fev[0]), .first_err_valid(fv[0])
`ifdef CVC_SIGNATURE_EN
        , .signature(sig[0])
`endif
    );
    comb_vector_checker #(.N_IN(6), .SETTLE(1), .EXPECTED(E1)) d1 (
        .clk(clk), .rst(rst), .start(start[1]), .vec_out(vec[1]), .y_in(y[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
        .first_err_vec(fev[1]), .first_err_valid(fv[1])
`ifdef CVC_SIGNATURE_EN
        , .signature(sig[1])
`endif
    );
    comb_vector_checker #(.N_IN(6), .SETTLE(1), .EXPECTED(64'h0)) d2 (
        .clk(clk), .rst(rst), .start(start[2]), .vec_out(vec[2]), .y_in(y[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
        .first_err_vec(fev[2]), .first_err_valid(fv[2])
`ifdef CVC_SIGNATURE_EN
        , .signature(sig[2])
`endif
    );
    comb_vector_checker #(.N_IN(6), .SETTLE(3), .EXPECTED(E0)) d3 (
        .clk(clk), .rst(rst), .start(start[3]), .vec_out(vec[3]), .y_in(y[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(errc[3]),
        .first_err_vec(fev[3]), .first_err_valid(fv[3])
`ifdef CVC_SIGNATURE_EN
        , .signature(sig[3])
`endif
    );

    task automatic do_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        checks++;
        if ({busy[i], done[i], vec[i]} !== {1'b1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL start_%0d: busy=%b done=%b vec=%0d, need busy=1 done=0 vec=0", i, busy[i], done[i], vec[i]);
        end
    endtask

    task automatic run_sweep(input int i, input int pulse_at, output int cyc);
        cyc = 0;
        while (!done[i] && cyc < 5000) begin
            start[i] = (cyc == pulse_at);
            @(posedge clk);
            #1;
            start[i] = 1'b0;
            cyc++;
            checks++;
            if (busy[i] && done[i]) begin
                errors++;
                $display("FAIL overlap_%0d: busy=1 done=1 at cycle %0d", i, cyc);
            end
        end
        checks++;
        if (!done[i]) begin
            errors++;
            $display("FAIL timeout_%0d: done=0 after %0d cycles, need done=1", i, cyc);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        checks++;
        if ({vec[i], busy[i], done[i], pass[i], errc[i], fev[i], fv[i]} !== '0) begin
            errors++;
            $display("FAIL %s_%0d: vec=%0d busy=%b done=%b pass=%b err=%0d fev=%0d fv=%b, need all 0",
                     tag, i, vec[i], busy[i], done[i], pass[i], errc[i], fev[i], fv[i]);
        end
`ifdef CVC_SIGNATURE_EN
        checks++;
        if (sig[i] !== 16'h0) begin
            errors++;
            $display("FAIL %s_sig_%0d: sig=%h, need 0000", tag, i, sig[i]);
        end
`endif
    endtask

    task automatic check_result(input int i, input string tag, input int cyc, input int exp_cyc,
                                input logic exp_pass, input int exp_err, input logic exp_fv, input int exp_fev);
        checks++;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s_latency: %0d cycles, need %0d", tag, cyc, exp_cyc);
        end
        checks++;
        if ({pass[i], busy[i], errc[i], fv[i]} !== {exp_pass, 1'b0, 7'(exp_err), exp_fv}) begin
            errors++;
            $display("FAIL %s_status: pass=%b busy=%b err=%0d fv=%b, need pass=%b busy=0 err=%0d fv=%b",
                     tag, pass[i], busy[i], errc[i], fv[i], exp_pass, exp_err, exp_fv);
        end
        checks++;
        if (exp_fv && fev[i] !== 6'(exp_fev)) begin
            errors++;
            $display("FAIL %s_first: fev=%0d, need %0d", tag, fev[i], exp_fev);
        end
        checks++;
        if (vec[i] !== 6'd63) begin
            errors++;
            $display("FAIL %s_hold: vec=%0d, need 63", tag, vec[i]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_idle(i, "reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loopback();
        int cyc;
        do_start(0);
        run_sweep(0, -1, cyc);
        check_result(0, "loopback", cyc, 128, 1'b1, 0, 1'b0, 0);
    endtask

    task automatic test_stuck_zero();
        int cyc;
        do_start(1);
        run_sweep(1, -1, cyc);
        check_result(1, "stuck0", cyc, 128, 1'b0, 3, 1'b1, 0);
    endtask

    task automatic test_and_pattern();
        int cyc;
        do_start(2);
        run_sweep(2, -1, cyc);
        check_result(2, "and_abf", cyc, 128, 1'b0, 8, 1'b1, 49);
    endtask

    task automatic test_settle();
        int cyc;
        do_start(3);
        run_sweep(3, 50, cyc);
        check_result(3, "settle3", cyc, 256, 1'b1, 0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int cyc;
        flip_en = 1'b1;
        flip_v  = 6'd10;
        do_start(0);
        while (vec[0] != 6'd20 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (vec[0] !== 6'd20 || errc[0] !== 7'd1) begin
            errors++;
            $display("FAIL midsweep_reach: vec=%0d err=%0d, need vec=20 err=1", vec[0], errc[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        check_idle(0, "midrst");
        @(negedge clk);
        rst = 1'b0;
        start[0] = 1'b0;
        flip_en = 1'b0;
        @(posedge clk);
        #1;
        check_idle(0, "postrst");
        do_start(0);
        run_sweep(0, -1, cyc);
        check_result(0, "resweep", cyc, 128, 1'b1, 0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int cyc;
`ifdef CVC_SIGNATURE_EN
        logic [15:0] s1;
`endif
        do_start(0);
        run_sweep(0, -1, cyc);
`ifdef CVC_SIGNATURE_EN
        s1 = sig[0];
`endif
        do_start(0);
        run_sweep(0, -1, cyc);
        check_result(0, "repeat", cyc, 128, 1'b1, 0, 1'b0, 0);
`ifdef CVC_SIGNATURE_EN
        checks++;
        if (sig[0] !== s1) begin
            errors++;
            $display("FAIL sig_repeat: sig=%h, need %h", sig[0], s1);
        end
`endif
        flip_en = 1'b1;
        flip_v  = 6'd10;
        do_start(0);
        run_sweep(0, -1, cyc);
        check_result(0, "flip", cyc, 128, 1'b0, 1, 1'b1, 10);
`ifdef CVC_SIGNATURE_EN
        checks++;
        if (sig[0] === s1) begin
            errors++;
            $display("FAIL sig_flip: sig=%h, need a value other than %h", sig[0], s1);
        end
`endif
        flip_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_stuck_zero();
        test_and_pattern();
        test_settle();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
